// File: rtl/dma_sched_pkg.sv
// Shared types, engine flag positions and status helper for the DMA channel scheduler.
package dma_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        RELEASE   = 3'd3,
        CPL       = 3'd4
    } sched_state_e;

    typedef enum logic [1:0] {
        CPL_OK           = 2'b00,
        CPL_LOAD_DENIED  = 2'b01,
        CPL_STORE_DENIED = 2'b10,
        CPL_TIMEOUT      = 2'b11
    } cpl_status_e;

    localparam int unsigned VALID_LOAD_BIT  = 1;
    localparam int unsigned VALID_STORE_BIT = 2;
    localparam int unsigned VALID_DONE_BIT  = 3;

    typedef struct packed {
        logic [63:0] length;
        logic [63:0] src;
        logic [63:0] dst;
    } dma_desc_t;

    // A denied load masks whatever the store flag says.
    function automatic cpl_status_e classify_flags(input logic load, input logic store);
        if (!load) begin
            return CPL_LOAD_DENIED;
        end
        if (!store) begin
            return CPL_STORE_DENIED;
        end
        return CPL_OK;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter: search from ptr_i upward with wrap; reports the pointer after an accept.
module dma_rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned IDX_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    input  logic              advance_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic [IDX_W-1:0]  ptr_next_o
);

    logic w_found;
    int   w_idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            w_idx = (int'(ptr_i) + k) % int'(NUM_CH);
            if (!w_found && req_i[w_idx]) begin
                w_found        = 1'b1;
                grant_o[w_idx] = 1'b1;
                grant_idx_o    = IDX_W'(w_idx);
            end
        end
    end

    always_comb begin
        ptr_next_o = ptr_i;
        if (advance_i && w_found) begin
            ptr_next_o = (int'(grant_idx_o) == int'(NUM_CH) - 1) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/dma_chan_sched.sv
// Round-robin scheduler feeding one DMA engine from NUM_CH descriptor requesters.
// Optional WAIT_DONE watchdog is built when DMA_SCHED_TIMEOUT_EN is defined.
module dma_chan_sched #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CH-1:0]            req_valid_i,
    output logic [NUM_CH-1:0]            req_ready_o,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_length_i,
    input  logic [NUM_CH*64-1:0]         req_src_addr_i,
    input  logic [NUM_CH*64-1:0]         req_dst_addr_i,
    output logic [NUM_CH-1:0]            cpl_valid_o,
    output logic [1:0]                   cpl_status_o,
    output logic                         busy_o,
    output logic [DATA_WIDTH-1:0]        dma_start_o,
    output logic [DATA_WIDTH-1:0]        dma_length_o,
    output logic [DATA_WIDTH-1:0]        dma_src_lsb_o,
    output logic [DATA_WIDTH-1:0]        dma_src_msb_o,
    output logic [DATA_WIDTH-1:0]        dma_dst_lsb_o,
    output logic [DATA_WIDTH-1:0]        dma_dst_msb_o,
    input  logic [DATA_WIDTH-1:0]        dma_valid_i,
    output logic [DATA_WIDTH-1:0]        dma_done_o
);
    import dma_sched_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_CH);

    sched_state_e      r_state, w_state_next;
    cpl_status_e       r_status, w_status_next;
    dma_desc_t         r_desc;
    logic [IDX_W-1:0]  r_ptr, r_ch, w_ptr_next, w_grant_idx;
    logic [NUM_CH-1:0] w_grant;
    logic              w_handshake, w_done_flag, w_tmo_hit, w_active;

    assign w_done_flag = dma_valid_i[VALID_DONE_BIT];
    assign w_handshake = (r_state == IDLE) && (|req_valid_i);
    assign w_active    = (r_state != IDLE);

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (r_ptr),
        .advance_i   (w_handshake),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .ptr_next_o  (w_ptr_next)
    );

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside WAIT_DONE so every entry starts a fresh count.
    always_ff @(posedge clk_i) begin
        if (rst_i || r_state != WAIT_DONE) begin
            r_tmo_cnt <= '0;
        end else if (!w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_tmo_hit    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        unique case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: w_state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (w_done_flag) begin
                    w_status_next = classify_flags(dma_valid_i[VALID_LOAD_BIT],
                                                   dma_valid_i[VALID_STORE_BIT]);
                    w_state_next  = RELEASE;
                end else if (w_tmo_hit) begin
                    w_status_next = CPL_TIMEOUT;
                    w_state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_done_flag) begin
                    w_state_next = CPL;
                end
            end
            CPL:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_status <= CPL_OK;
            r_ptr    <= '0;
            r_ch     <= '0;
            r_desc   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_status <= w_status_next;
            r_ptr    <= w_ptr_next;
            if (w_handshake) begin
                r_ch        <= w_grant_idx;
                r_desc.length <= 64'(req_length_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH]);
                r_desc.src  <= req_src_addr_i[w_grant_idx*64 +: 64];
                r_desc.dst  <= req_dst_addr_i[w_grant_idx*64 +: 64];
            end
        end
    end

    assign req_ready_o   = (r_state == IDLE) ? w_grant : '0;
    assign busy_o        = w_active;
    assign dma_start_o   = {{(DATA_WIDTH-1){1'b0}}, r_state == ISSUE};
    assign dma_done_o    = {{(DATA_WIDTH-1){1'b0}}, r_state == RELEASE};
    assign cpl_valid_o   = (r_state == CPL) ? (NUM_CH'(1) << r_ch) : '0;
    assign cpl_status_o  = (r_state == CPL) ? r_status : CPL_OK;
    assign dma_length_o  = w_active ? DATA_WIDTH'(r_desc.length) : '0;
    assign dma_src_lsb_o = w_active ? DATA_WIDTH'(r_desc.src[31:0]) : '0;
    assign dma_src_msb_o = w_active ? DATA_WIDTH'(r_desc.src[63:32]) : '0;
    assign dma_dst_lsb_o = w_active ? DATA_WIDTH'(r_desc.dst[31:0]) : '0;
    assign dma_dst_msb_o = w_active ? DATA_WIDTH'(r_desc.dst[63:32]) : '0;

    logic w_unused_bits;
    assign w_unused_bits = ^{dma_valid_i[DATA_WIDTH-1:4], dma_valid_i[0], r_desc.length};

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched: arbitration order, engine handshake, status, reset, watchdog.
module tb_dma_chan_sched;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned TMO    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] req_valid, req_ready, cpl_valid;
    logic [NUM_CH*DW-1:0] req_length;
    logic [NUM_CH*64-1:0] req_src, req_dst;
    logic [1:0]        cpl_status;
    logic              busy;
    logic [DW-1:0]     dma_start, dma_length, dma_src_lsb, dma_src_msb;
    logic [DW-1:0]     dma_dst_lsb, dma_dst_msb, dma_valid, dma_done;

    logic [63:0] src_tab [NUM_CH];
    logic [63:0] dst_tab [NUM_CH];
    logic [31:0] len_tab [NUM_CH];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dma_chan_sched #(
        .NUM_CH         (NUM_CH),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_length_i   (req_length),
        .req_src_addr_i (req_src),
        .req_dst_addr_i (req_dst),
        .cpl_valid_o    (cpl_valid),
        .cpl_status_o   (cpl_status),
        .busy_o         (busy),
        .dma_start_o    (dma_start),
        .dma_length_o   (dma_length),
        .dma_src_lsb_o  (dma_src_lsb),
        .dma_src_msb_o  (dma_src_msb),
        .dma_dst_lsb_o  (dma_dst_lsb),
        .dma_dst_msb_o  (dma_dst_msb),
        .dma_valid_i    (dma_valid),
        .dma_done_o     (dma_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with req_valid already driven; walks one descriptor through to IDLE.
    task automatic serve(input string tag, input logic [3:0] exp_grant, input logic [31:0] flags,
                         input logic [1:0] exp_status, input logic [63:0] exp_src,
                         input logic [31:0] exp_len);
        #1;
        check_eq({tag, ".ready"}, req_ready, exp_grant);
        tick();
        check_eq({tag, ".start"}, dma_start, 1);
        check_eq({tag, ".src_lsb"}, dma_src_lsb, exp_src[31:0]);
        check_eq({tag, ".src_msb"}, dma_src_msb, exp_src[63:32]);
        check_eq({tag, ".length"}, dma_length, exp_len);
        check_eq({tag, ".ready_busy"}, req_ready, 0);
        tick();
        check_eq({tag, ".start_off"}, dma_start, 0);
        tick();
        dma_valid = flags;
        tick();
        check_eq({tag, ".done"}, dma_done, 1);
        tick();
        check_eq({tag, ".done_held"}, dma_done, 1);
        dma_valid = '0;
        tick();
        check_eq({tag, ".cpl"}, cpl_valid, exp_grant);
        check_eq({tag, ".status"}, cpl_status, exp_status);
        check_eq({tag, ".src_stable"}, dma_src_lsb, exp_src[31:0]);
        tick();
        check_eq({tag, ".cpl_clr"}, cpl_valid, 0);
        check_eq({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        src_tab[0] = 64'h0000_0000_1000_0000;
        src_tab[1] = 64'h0000_0002_2000_0000;
        src_tab[2] = 64'h0000_0000_8000_0010;
        src_tab[3] = 64'h0000_0003_4000_0040;
        dst_tab[0] = 64'h0000_0000_1100_0000;
        dst_tab[1] = 64'h0000_0000_2200_0000;
        dst_tab[2] = 64'h0000_0000_8000_1000;
        dst_tab[3] = 64'h0000_0000_4400_0000;
        len_tab[0] = 32'd16;
        len_tab[1] = 32'd7;
        len_tab[2] = 32'd3;
        len_tab[3] = 32'd100;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            req_length[c*DW +: DW] = len_tab[c];
            req_src[c*64 +: 64]    = src_tab[c];
            req_dst[c*64 +: 64]    = dst_tab[c];
        end
        rst       = 1'b1;
        req_valid = '0;
        dma_valid = '0;
        repeat (3) tick();

        check_eq("rst.busy", busy, 0);
        check_eq("rst.ready", req_ready, 0);
        check_eq("rst.cpl", cpl_valid, 0);
        check_eq("rst.start", dma_start, 0);
        check_eq("rst.done", dma_done, 0);
        check_eq("rst.src_lsb", dma_src_lsb, 0);
        check_eq("rst.length", dma_length, 0);

        rst = 1'b0;
        tick();

        // Single requester on channel 2.
        req_valid = 4'b0100;
        serve("ch2", 4'b0100, 32'hE, 2'b00, src_tab[2], len_tab[2]);
        req_valid = '0;

        // All four requesting from reset: strict 0,1,2,3 order.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            serve("all", 4'(1 << i), 32'hE, 2'b00, src_tab[i], len_tab[i]);
        end
        req_valid = '0;

        // Status classes; second ch0 request wraps the search from pointer 1.
        req_valid = 4'b0001;
        serve("load_den", 4'b0001, 32'h8, 2'b01, src_tab[0], len_tab[0]);
        serve("store_den", 4'b0001, 32'hA, 2'b10, src_tab[0], len_tab[0]);
        req_valid = 4'b1000;
        serve("st_only", 4'b1000, 32'hC, 2'b01, src_tab[3], len_tab[3]);
        req_valid = '0;

        // Request withdrawn before the edge leaves the scheduler idle.
        tick();
        req_valid = 4'b0010;
        #1;
        check_eq("drop.ready", req_ready, 4'b0010);
        req_valid = '0;
        tick();
        check_eq("drop.busy", busy, 0);
        check_eq("drop.ready_clr", req_ready, 0);

        // Reset while waiting on the engine.
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        tick();
        check_eq("rstw.busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        check_eq("rstw.busy", busy, 0);
        check_eq("rstw.start", dma_start, 0);
        check_eq("rstw.done", dma_done, 0);
        check_eq("rstw.cpl", cpl_valid, 0);
        check_eq("rstw.status", cpl_status, 0);
        check_eq("rstw.src_lsb", dma_src_lsb, 0);
        check_eq("rstw.length", dma_length, 0);
        rst = 1'b0;
        tick();
        check_eq("rstw.no_cpl", cpl_valid, 0);
        req_valid = 4'b1111;
        serve("rstw.ptr0", 4'b0001, 32'hE, 2'b00, src_tab[0], len_tab[0]);
        req_valid = '0;

        // Engine never raises DONE.
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        tick();
`ifdef DMA_SCHED_TIMEOUT_EN
        repeat (TMO - 1) tick();
        check_eq("tmo.not_yet", dma_done, 0);
        tick();
        check_eq("tmo.release", dma_done, 1);
        tick();
        check_eq("tmo.cpl", cpl_valid, 4'b0100);
        check_eq("tmo.status", cpl_status, 2'b11);
        tick();
        check_eq("tmo.idle", busy, 0);
`else
        repeat (40) tick();
        check_eq("hang.busy", busy, 1);
        check_eq("hang.done", dma_done, 0);
        check_eq("hang.cpl", cpl_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("hang.rst_busy", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
